// File: rtl/snes_video_src.sv
// Synthetic SNES PPU/DSP source: dot/line/field timing, four test patterns,
// DRAM refresh window and a sawtooth audio stream, all frozen while pause is high.
module snes_video_src #(
  parameter int CLK_PER_DOT     = 4,
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FIELD = 262,
  parameter int ACTIVE_DOTS     = 256,
  parameter int ACTIVE_LINES    = 224,
  parameter int REFRESH_DOT     = 134,
  parameter int REFRESH_CLKS    = 40,
  parameter int AUDIO_DIV       = 671,
  parameter int INTERLACE       = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pause,
  input  logic [1:0]  mode,
  input  logic [14:0] solid_color,
  input  logic        audio_en,
  output logic        dotclk,
  output logic        hblank,
  output logic        vblank,
  output logic [8:0]  xs,
  output logic [8:0]  ys,
  output logic [14:0] rgb5,
  output logic        snes_refresh,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        audio_ready
);
  localparam int PW = $clog2(CLK_PER_DOT);
  localparam int DW = ($clog2(DOTS_PER_LINE) > 8) ? $clog2(DOTS_PER_LINE) : 8;
  localparam int LW = ($clog2(LINES_PER_FIELD) > 8) ? $clog2(LINES_PER_FIELD) : 8;
  localparam int AW = $clog2(AUDIO_DIV);
  localparam int RW = ($clog2(REFRESH_CLKS) > 0) ? $clog2(REFRESH_CLKS) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_DOT - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(CLK_PER_DOT / 2);
  localparam logic [DW-1:0] DOT_LAST  = DW'(DOTS_PER_LINE - 1);
  localparam logic [DW-1:0] DOT_ACT   = DW'(ACTIVE_DOTS);
  localparam logic [DW-1:0] DOT_REF   = DW'(REFRESH_DOT);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FIELD - 1);
  localparam logic [LW-1:0] LINE_ACT  = LW'(ACTIVE_LINES);
  localparam logic [AW-1:0] ADIV_LAST = AW'(AUDIO_DIV - 1);
  localparam logic [RW-1:0] REF_INIT  = RW'(REFRESH_CLKS - 1);
  // A window that would spill into the next line is suppressed entirely
  localparam bit REF_EN =
    (REFRESH_DOT * CLK_PER_DOT + REFRESH_CLKS) < (DOTS_PER_LINE * CLK_PER_DOT);

  logic [PW-1:0] phase;
  logic [DW-1:0] dot;
  logic [LW-1:0] line;
  logic          field;
  logic [7:0]    frame;
  logic [RW-1:0] ref_cnt;
  logic [AW-1:0] adiv;
  logic [1:0]    mode_q;
  logic [14:0]   solid_q;
  logic [14:0]   pix;

  logic ph_wrap, dot_wrap, line_wrap, frame_start, ref_start, dot_hi;
  logic blank_d, blank_l;
  logic [1:0]  mode_e;
  logic [14:0] solid_e;
  logic [7:0]  x, y;
  logic [15:0] l_next;

  assign ph_wrap     = (phase == PH_LAST);
  assign dot_wrap    = (dot == DOT_LAST);
  assign line_wrap   = (line == LINE_LAST);
  assign frame_start = (phase == '0) && (dot == '0) && (line == '0);
  assign ref_start   = REF_EN && (phase == '0) && (dot == DOT_REF);
  assign dot_hi      = (phase >= PH_HALF);
  assign blank_d     = (dot >= DOT_ACT);
  assign blank_l     = (line >= LINE_ACT);
  assign x           = dot[7:0];
  assign y           = line[7:0];
  assign l_next      = audio_l + 16'h0100;

  // Pattern controls latch at the first dot of a field; that dot already uses the new values
  assign mode_e  = frame_start ? mode : mode_q;
  assign solid_e = frame_start ? solid_color : solid_q;

  always_comb begin
    pix = '0;
    case (mode_e)
      2'd0:    pix = {{5{x[7]}}, {5{x[6]}}, {5{x[5]}}};
      2'd1:    pix = {5'((x ^ y) >> 3), y[7:3], x[7:3]};
      2'd2:    pix = solid_e;
      default: pix = (|((x + frame) & 8'h08) ^ y[3]) ? 15'h7FFF : 15'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= '0; dot <= '0; line <= '0; field <= 1'b0; frame <= '0;
      ref_cnt <= '0; adiv <= '0; mode_q <= '0; solid_q <= '0;
      dotclk <= 1'b0; hblank <= 1'b0; vblank <= 1'b0; xs <= '0; ys <= '0;
      rgb5 <= '0; snes_refresh <= 1'b0;
      audio_l <= '0; audio_r <= '0; audio_ready <= 1'b0;
    end else if (pause) begin
      audio_ready <= 1'b0;
    end else begin
      phase <= ph_wrap ? '0 : phase + PW'(1);
      if (ph_wrap) begin
        dot <= dot_wrap ? '0 : dot + DW'(1);
        if (dot_wrap) begin
          line <= line_wrap ? '0 : line + LW'(1);
          if (line_wrap) begin
            frame <= frame + 8'd1;
            field <= (INTERLACE != 0) ? ~field : 1'b0;
          end
        end
      end
      if (frame_start) begin
        mode_q  <= mode;
        solid_q <= solid_color;
      end

      dotclk <= dot_hi;
      hblank <= blank_d;
      vblank <= blank_l;
      xs     <= {x, dot_hi};
      ys     <= {field, y};
      if (phase == '0)
        rgb5 <= (blank_d || blank_l) ? 15'h0000 : pix;

      // Counts only unpaused clocks, so a pause stretches the window in wall time
      if (ref_start) begin
        snes_refresh <= 1'b1;
        ref_cnt      <= REF_INIT;
      end else if (ref_cnt != '0) begin
        ref_cnt <= ref_cnt - RW'(1);
      end else begin
        snes_refresh <= 1'b0;
      end

      audio_ready <= 1'b0;
      if (adiv == ADIV_LAST) begin
        adiv <= '0;
        if (audio_en) begin
          audio_l     <= l_next;
          audio_r     <= ~l_next + 16'd1;
          audio_ready <= 1'b1;
        end
      end else begin
        adiv <= adiv + AW'(1);
      end
    end
  end
endmodule
